// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive decoder: receiver FSM states and the
// decoded-byte FIFO entry.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    typedef struct packed {
        logic       frameError;
        logic [7:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO of decoded UART entries. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  rx_entry_t                wdata_i,
    input  logic                     pop_i,
    output rx_entry_t                rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned CountW = PtrW + 1;

    rx_entry_t         mem_q [Depth];
    rx_entry_t         mem_d [Depth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CountW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CountW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CountW'(1);
        end
    end

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_decoder.sv
// 8N1 UART receiver: synchronises the line, validates start bits, samples
// mid-bit and queues decoded bytes behind a valid/ready stream.
module uart_rx_decoder
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       io_clock,
    input  logic       io_reset,
    input  logic       io_rxd,
    output logic       io_stream_valid,
    input  logic       io_stream_ready,
    output logic [7:0] io_stream_payload,
    output logic       io_stream_frameError,
    output logic       io_overflow,
    input  logic       io_clearOverflow,
    output logic       io_busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);

    logic              sync1_q, sync2_q, rxd_prev_q;
    logic              rxd_s, rx_fall;
    rx_state_t         state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              overflow_q, overflow_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    rx_entry_t         fifo_wdata, fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign rxd_s   = sync2_q;
    assign rx_fall = rxd_prev_q && !rxd_s;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        fifo_push  = 1'b0;
        fifo_wdata = '{frameError: ~rxd_s, data: shift_q};
        if (state_q != IDLE && cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (rx_fall) begin
                    state_d = START;
                    cnt_d   = HalfLoad;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    // A high line at mid start bit is a glitch, not a frame.
                    if (rxd_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                        cnt_d   = FullLoad;
                    end
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d[idx_q] = rxd_s;
                    cnt_d          = FullLoad;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    fifo_push = 1'b1;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    assign fifo_pop = io_stream_valid && io_stream_ready;

    // Set wins over clear when a drop coincides with the clear request.
    always_comb begin
        overflow_d = overflow_q;
        if (io_clearOverflow) begin
            overflow_d = 1'b0;
        end
        if (fifo_push && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge io_clock or negedge io_reset) begin
        if (!io_reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rxd_prev_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync1_q    <= io_rxd;
            sync2_q    <= sync1_q;
            rxd_prev_q <= rxd_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            overflow_q <= overflow_d;
        end
    end

    uart_rx_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (io_clock),
        .rst_ni  (io_reset),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        assert (32'(fifo_count) <= FIFO_DEPTH);
        assert (fifo_empty == (fifo_count == '0));
    end

    assign io_stream_valid      = !fifo_empty;
    assign io_stream_payload    = fifo_head.data;
    assign io_stream_frameError = fifo_head.frameError;
    assign io_overflow          = overflow_q;
    assign io_busy              = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_decoder.sv
// Bench for uart_rx_decoder: directed frames plus random traffic, checked
// against a queue of expected {frameError, byte} entries.
module tb_uart_rx_decoder;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       ready = 1'b0;
    logic       clr = 1'b0;
    logic       valid;
    logic [7:0] payload;
    logic       fe;
    logic       ovf;
    logic       busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  exp_head;
    bit          rand_rdy = 1'b0;

    uart_rx_decoder #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .io_clock             (clk),
        .io_reset             (rst_n),
        .io_rxd               (rxd),
        .io_stream_valid      (valid),
        .io_stream_ready      (ready),
        .io_stream_payload    (payload),
        .io_stream_frameError (fe),
        .io_overflow          (ovf),
        .io_clearOverflow     (clr),
        .io_busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted beat must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'({fe, payload}), 32'hFFFF_FFFF);
            end else begin
                exp_head = exp_q.pop_front();
                check("beat", 32'({fe, payload}), 32'(exp_head));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap,
                              input bit expect_it);
        if (expect_it) exp_q.push_back({~stop, d});
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        repeat (gap) drive_bit(1'b1);
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((exp_q.size() != 0 || valid) && k < 2000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
    endtask

    initial begin
        int k;
        logic [7:0] d;
        logic       stop;
        int         gap;

        cycles(3);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_payload", 32'(payload), 32'd0);
        check("rst_fe", 32'(fe), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        cycles(4);

        // Clean frame, ready high.
        ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1, 1'b1);
        wait_drain("t1");
        check("t1_ovf", 32'(ovf), 32'd0);

        // Stop bit low, then a normal frame.
        send_frame(8'h3C, 1'b0, 1, 1'b1);
        send_frame(8'h01, 1'b1, 1, 1'b1);
        wait_drain("t2");

        // Short low glitch on an idle line.
        rxd = 1'b0;
        cycles(4);
        rxd = 1'b1;
        k = 0;
        while (!busy && k < 10) begin cycles(1); k++; end
        check("t3_busy_rise", 32'(busy), 32'd1);
        k = 0;
        while (busy && k < 10) begin cycles(1); k++; end
        check("t3_busy_fall", 32'(busy), 32'd0);
        cycles(4 * CPB);
        check("t3_no_beat", 32'(valid), 32'd0);

        // Five frames into a stalled 4-deep FIFO: the fifth is dropped.
        ready = 1'b0;
        for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1, 0, i < 4);
        cycles(CPB);
        check("t4_ovf_set", 32'(ovf), 32'd1);
        check("t4_valid", 32'(valid), 32'd1);
        check("t4_head", 32'(payload), 32'h10);
        ready = 1'b1;
        wait_drain("t4");
        check("t4_ovf_sticky", 32'(ovf), 32'd1);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        check("t4_ovf_clear", 32'(ovf), 32'd0);

        // Pop on the very cycle a push lands in a full FIFO.
        ready = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(8'h20 + 8'(i), 1'b1, 1, 1'b1);
        fork
            send_frame(8'h24, 1'b1, 1, 1'b1);
            begin
                int j = 0;
                while (!busy && j < 100) begin @(negedge clk); j++; end
                check("t5_busy_seen", 32'(busy), 32'd1);
                // Start state is entered one cycle after edge detect; stop
                // sample falls 152 cycles after the edge.
                cycles(151);
                ready = 1'b1;
                cycles(1);
                ready = 1'b0;
            end
        join
        cycles(4);
        check("t5_ovf", 32'(ovf), 32'd0);
        check("t5_left_before_drain", 32'(exp_q.size()), 32'd4);
        ready = 1'b1;
        wait_drain("t5");

        // Reset mid-frame with a queued byte.
        ready = 1'b0;
        send_frame(8'h77, 1'b1, 1, 1'b1);
        rxd = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        cycles(CPB / 2);
        check("t6_busy_pre", 32'(busy), 32'd1);
        check("t6_valid_pre", 32'(valid), 32'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("t6_valid", 32'(valid), 32'd0);
        check("t6_payload", 32'(payload), 32'd0);
        check("t6_fe", 32'(fe), 32'd0);
        check("t6_ovf", 32'(ovf), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        rxd = 1'b1;
        cycles(3);
        rst_n = 1'b1;
        cycles(2 * CPB);
        ready = 1'b1;
        send_frame(8'h5A, 1'b1, 1, 1'b1);
        wait_drain("t6");

        // Random bytes, stop bits, gaps and ready.
        rand_rdy = 1'b1;
        for (int i = 0; i < 24; i++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            send_frame(d, stop, gap, 1'b1);
        end
        rand_rdy = 1'b0;
        cycles(1);
        ready = 1'b1;
        wait_drain("t7");
        check("t7_ovf", 32'(ovf), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_decoder.md
# uart_rx_decoder

Serial receive decoder that consumes the `uartStd` transmit line driven by the SoC top and turns it into a byte stream. It sits directly downstream of the top-level UART pin: it synchronises the asynchronous line, detects and validates start bits, samples 8N1 frames mid-bit and buffers the decoded bytes in a small FIFO behind a valid/ready stream. It is synthesisable, so the same RTL serves as a bench monitor and as a loop-back receiver on FPGA targets.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: `io_clock` cycles per UART bit (100 MHz / 115200). Must be ≥ 8.
- `FIFO_DEPTH`, 4: decoded-byte buffer entries, power of two, ≥ 2.

Ports:
- `io_clock` in 1: single clock for all logic.
- `io_reset` in 1: asynchronous, active-low reset.
- `io_rxd` in 1: serial line, idle high; asynchronous to `io_clock`.
- `io_stream_valid` out 1: FIFO head holds a byte.
- `io_stream_ready` in 1: consumer accepts the head byte this cycle.
- `io_stream_payload` out 8: head byte, LSB first on the line.
- `io_stream_frameError` out 1: head byte was received with stop bit = 0.
- `io_overflow` out 1: sticky; a completed byte was dropped because the FIFO was full.
- `io_clearOverflow` in 1: synchronous clear of `io_overflow`.
- `io_busy` out 1: receiver FSM not in IDLE.

## Operation
- Reset values: `io_stream_valid`=0, `io_stream_payload`=0x00, `io_stream_frameError`=0, `io_overflow`=0, `io_busy`=0. FSM is in IDLE, FIFO is empty, and the synchroniser flops are set to 1.
- `io_rxd` passes through a 2-flop synchroniser (reset to 1). All logic uses the synchronised value `rxd_s`.
- FSM states:
  - IDLE → START on a falling edge of `rxd_s` (previous 1, current 0). The bit counter is loaded with `CLKS_PER_BIT/2 - 1`.
  - START: when the counter reaches 0, sample `rxd_s`. If it is 1, treat it as a glitch and return to IDLE with no output. If it is 0, go to DATA with bit index 0 and the counter loaded with `CLKS_PER_BIT - 1`.
  - DATA: each time the counter reaches 0, shift `rxd_s` into bit[index], LSB first. After index 7, go to STOP. The counter reloads `CLKS_PER_BIT - 1` on every sample.
  - STOP: when the counter reaches 0, sample the stop bit, push {frameError = ~rxd_s, byte} to the FIFO, and return to IDLE in the same cycle. A new falling edge is accepted from the next cycle.
- FIFO rules:
  - A pop happens when `valid && ready`.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full (the occupancy count stays the same and nothing is dropped).
  - A push when the FIFO is full with no pop drops the byte and sets `io_overflow`.
  - If `io_clearOverflow` and an overflowing push occur in the same cycle, the set wins.
- Read and write pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally. Occupancy is held in a separate counter that is 1 bit wider.
- `io_stream_payload` and `io_stream_frameError` hold their values while `valid && !ready`. When the FIFO is empty they keep their last value (don't-care to consumers).
- A reset asserted mid-frame aborts the frame immediately. Partial bytes are discarded and the FIFO is emptied.

## Timing
- Synchroniser latency is 2 cycles from a change on `io_rxd` to `rxd_s`.
- The stop-bit sample falls 9.5·`CLKS_PER_BIT` cycles (±1) after the start edge is detected on `rxd_s`.
- `io_stream_valid` rises 1 cycle after the stop-sample cycle, because the FIFO is registered.
- Pop to the next head: the next byte is visible the cycle after the accepting edge.
- `io_busy` is high from the cycle after edge detection through the stop-sample cycle.

## Structure
- Shared package `uart_rx_pkg`:
  - FSM enum `rx_state_t` {IDLE, START, DATA, STOP}.
  - Packed struct `rx_entry_t` {frameError, data[7:0]}.
- One sub-module, `uart_rx_fifo`: a parameterised synchronous FIFO of `rx_entry_t` with push, pop, full, empty and count. The decoder top holds the synchroniser, the FSM and the overflow flag.

## Test plan
All benches use `CLKS_PER_BIT`=16 and drive `io_rxd` from a bench UART model.
- Single frame 0xA5 with stop = 1 and ready held high → one beat with payload 0xA5 and frameError 0; `io_overflow` stays 0.
- Frame 0x3C with stop = 0 → one beat with payload 0x3C and frameError 1; the next frame, 0x01, decodes normally.
- 4-cycle low glitch on an idle line → no beat; `io_busy` returns low within 8 cycles of the edge.
- Five back-to-back frames 0x10..0x14 with ready held low → four beats are queued (0x10..0x13) and `io_overflow` = 1. After releasing ready, exactly 0x10..0x13 drain; `io_clearOverflow` then clears the flag.
- Ready asserted on the same cycle a new byte is pushed into a full FIFO → no drop, `io_overflow` stays 0, and ordering is preserved.
- Reset asserted during data bit 4 of frame 0xFF → all outputs return to their reset values. The following frame 0x5A decodes correctly.
